// File: rtl/spec_disp_pkg.sv
// Shared constants, FSM state type and helpers for the spectrum display frame controller.
package spec_disp_pkg;

  localparam int unsigned BINS        = 256;   // samples per frame, sop..eop inclusive
  localparam int unsigned DW          = 32;    // sample / FIFO data width
  localparam int unsigned SCALE_SHIFT = 4;     // right shift before clipping
  localparam int unsigned MAX_LEN     = 1023;  // clip ceiling of the bar length
  localparam int unsigned FLUSH_CYC   = 8;     // cycles fifo_flush is held after an error

  localparam int unsigned BIN_CW   = $clog2(BINS);
  localparam int unsigned FLUSH_CW = $clog2(FLUSH_CYC + 1);
  localparam int unsigned STAT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOP,
    CAPTURE,
    HOLD,
    FLUSH
  } state_t;

  // Increment that sticks at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/cdc_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// A transition on level shows up as a one-cycle rise pulse 3 clk cycles later.
//  clk    in  destination clock
//  rst_n  in  asynchronous active-low reset
//  level  in  asynchronous level from another clock domain
//  rise   out one-cycle pulse on a synchronised 0->1 transition
module cdc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta   <= level;
      sync   <= meta;
      sync_d <= sync;
      rise   <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/spectrum_frame_ctrl.sv
// Captures one complete FFT spectrum frame per display request into the display FIFO,
// scaling and clipping each sample to a bar length. Bad frames are dropped with a flush.
//  clk_50m       in  system clock
//  rst_n         in  asynchronous active-low reset
//  fft_data      in  spectrum magnitude sample
//  fft_valid     in  sample valid
//  fft_sop       in  first sample of frame
//  fft_eop       in  last sample of frame
//  data_req      in  display frame request (pixel domain level)
//  wr_over       in  display finished reading (pixel domain level)
//  fifo_full     in  display FIFO full
//  fifo_wr_req   out FIFO write enable
//  fifo_wr_data  out scaled/clipped bar length
//  fifo_flush    out FIFO reset request
//  busy          out waiting for sop or capturing
//  frame_done    out pulse with the last write of a good frame
//  frame_err     out pulse on a discarded frame
//  frame_cnt     out good frames (wrapping)
//  err_cnt       out discarded frames (saturating)
module spectrum_frame_ctrl
  import spec_disp_pkg::*;
(
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic [DW-1:0]     fft_data,
  input  logic              fft_valid,
  input  logic              fft_sop,
  input  logic              fft_eop,
  input  logic              data_req,
  input  logic              wr_over,
  input  logic              fifo_full,
  output logic              fifo_wr_req,
  output logic [DW-1:0]     fifo_wr_data,
  output logic              fifo_flush,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] err_cnt
);

  state_t              state;
  state_t              state_nxt;
  logic [BIN_CW-1:0]   bin_cnt;
  logic [FLUSH_CW-1:0] flush_tmr;

  logic                req_rise;
  logic                over_rise;
  logic                accept;
  logic                last;
  logic                to_flush;
  logic                at_last;
  logic                cap_err;
  logic [DW-1:0]       scaled;
  logic [DW-1:0]       clipped;

  cdc_edge_sync u_req_sync (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .level (data_req),
    .rise  (req_rise)
  );

  cdc_edge_sync u_over_sync (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .level (wr_over),
    .rise  (over_rise)
  );

  // Scale and clip to the bar length.
  assign scaled  = fft_data >> SCALE_SHIFT;
  assign clipped = (scaled > DW'(MAX_LEN)) ? DW'(MAX_LEN) : scaled;

  // eop must land exactly on the last bin; early eop and missing eop are both a mismatch.
  assign at_last = (bin_cnt == BIN_CW'(BINS - 1));
  assign cap_err = fifo_full | fft_sop | (fft_eop ^ at_last);

  // Next state and per-sample decisions.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    to_flush  = 1'b0;
    case (state)
      IDLE: begin
        if (req_rise) state_nxt = WAIT_SOP;
      end
      WAIT_SOP: begin
        if (fft_valid && fft_sop) begin
          // A first sample that cannot be written, or a one-sample frame, is dropped.
          if (fifo_full || fft_eop) begin
            to_flush  = 1'b1;
            state_nxt = FLUSH;
          end else begin
            accept    = 1'b1;
            state_nxt = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (fft_valid) begin
          if (cap_err) begin
            to_flush  = 1'b1;
            state_nxt = FLUSH;
          end else begin
            accept = 1'b1;
            if (fft_eop) begin
              last      = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (over_rise) state_nxt = IDLE;
      end
      FLUSH: begin
        if (flush_tmr == FLUSH_CW'(FLUSH_CYC - 1)) state_nxt = WAIT_SOP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, write path, status pulses and statistics.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bin_cnt      <= '0;
      flush_tmr    <= '0;
      fifo_wr_req  <= 1'b0;
      fifo_wr_data <= '0;
      fifo_flush   <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      frame_cnt    <= '0;
      err_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt == WAIT_SOP) || (state_nxt == CAPTURE);
      fifo_flush  <= (state_nxt == FLUSH);
      fifo_wr_req <= accept;
      frame_done  <= last;
      frame_err   <= to_flush;
      flush_tmr   <= (state == FLUSH) ? flush_tmr + FLUSH_CW'(1) : '0;
      if (accept) begin
        fifo_wr_data <= clipped;
        bin_cnt      <= (state == WAIT_SOP) ? BIN_CW'(1) : bin_cnt + BIN_CW'(1);
      end
      // Counters trail their pulses by one cycle.
      if (frame_done) frame_cnt <= frame_cnt + STAT_W'(1);
      if (frame_err)  err_cnt   <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_spectrum_frame_ctrl.sv
// Directed bench for spectrum_frame_ctrl: good frames, ignored requests, error flushes, reset.
module tb_spectrum_frame_ctrl;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic [31:0] fft_data;
  logic        fft_valid;
  logic        fft_sop;
  logic        fft_eop;
  logic        data_req;
  logic        wr_over;
  logic        fifo_full;
  logic        fifo_wr_req;
  logic [31:0] fifo_wr_data;
  logic        fifo_flush;
  logic        busy;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Monitor state, cleared between scenarios.
  logic [31:0] wr_log [0:255];
  int          wr_n;
  int          done_n;
  int          done_at;
  int          err_n;
  int          flush_n;
  logic        busy_seen;

  spectrum_frame_ctrl dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .fft_data     (fft_data),
    .fft_valid    (fft_valid),
    .fft_sop      (fft_sop),
    .fft_eop      (fft_eop),
    .data_req     (data_req),
    .wr_over      (wr_over),
    .fifo_full    (fifo_full),
    .fifo_wr_req  (fifo_wr_req),
    .fifo_wr_data (fifo_wr_data),
    .fifo_flush   (fifo_flush),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk_50m = ~clk_50m;

  always @(negedge clk_50m) begin
    if (fifo_wr_req) begin
      if (wr_n < 256) wr_log[wr_n] = fifo_wr_data;
      wr_n = wr_n + 1;
    end
    if (frame_done) begin
      done_n  = done_n + 1;
      done_at = wr_n;
    end
    if (frame_err)  err_n   = err_n + 1;
    if (fifo_flush) flush_n = flush_n + 1;
    if (busy)       busy_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  task automatic clr_log();
    wr_n      = 0;
    done_n    = 0;
    done_at   = -1;
    err_n     = 0;
    flush_n   = 0;
    busy_seen = 1'b0;
  endtask

  // Stream n samples (data = k*1000); -1 disables an option.
  task automatic send_frame(input int n, input int eop_at, input int sop2_at,
                            input int full_at, input int req_at);
    for (int k = 0; k < n; k++) begin
      fft_valid = 1'b1;
      fft_data  = 32'(k * 1000);
      fft_sop   = (k == 0) || (k == sop2_at);
      fft_eop   = (k == eop_at);
      fifo_full = (k == full_at);
      if (k == req_at) data_req = 1'b1;
      step(1);
    end
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
    fft_eop   = 1'b0;
    fifo_full = 1'b0;
    step(3);
  endtask

  task automatic arm();
    data_req = 1'b0;
    step(4);
    data_req = 1'b1;
    step(5);
  endtask

  task automatic release_hold();
    wr_over = 1'b1;
    step(6);
    wr_over = 1'b0;
    step(3);
  endtask

  initial begin
    rst_n     = 1'b0;
    fft_data  = '0;
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
    fft_eop   = 1'b0;
    data_req  = 1'b0;
    wr_over   = 1'b0;
    fifo_full = 1'b0;
    clr_log();
    step(3);
    chk("rst_wr_req", 32'(fifo_wr_req), 0);
    chk("rst_flush", 32'(fifo_flush), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    rst_n = 1'b1;
    step(3);

    // 1: one good ramp frame
    clr_log();
    arm();
    chk("t1_busy_armed", 32'(busy), 1);
    send_frame(256, 255, -1, -1, -1);
    chk("t1_writes", 32'(wr_n), 256);
    chk("t1_d0", wr_log[0], 0);
    chk("t1_d1", wr_log[1], 62);
    chk("t1_d15", wr_log[15], 937);
    chk("t1_d16", wr_log[16], 1000);
    chk("t1_d17", wr_log[17], 1023);
    chk("t1_d255", wr_log[255], 1023);
    chk("t1_done_n", 32'(done_n), 1);
    chk("t1_done_at_last", 32'(done_at), 256);
    chk("t1_frame_cnt", 32'(frame_cnt), 1);
    chk("t1_busy_hold", 32'(busy), 0);
    release_hold();

    // 2: no request -> nothing; request mid-frame -> waits for next sop
    data_req = 1'b0;
    step(4);
    clr_log();
    send_frame(256, 255, -1, -1, -1);
    chk("t2_noreq_writes", 32'(wr_n), 0);
    chk("t2_noreq_busy", 32'(busy_seen), 0);
    send_frame(256, 255, -1, -1, 10);
    chk("t2_midreq_writes", 32'(wr_n), 0);
    chk("t2_midreq_busy", 32'(busy), 1);
    send_frame(256, 255, -1, -1, -1);
    chk("t2_next_writes", 32'(wr_n), 256);
    chk("t2_frame_cnt", 32'(frame_cnt), 2);

    // 5: request toggles in HOLD are ignored; wr_over frees the controller
    clr_log();
    arm();
    send_frame(256, 255, -1, -1, -1);
    chk("t5_hold_writes", 32'(wr_n), 0);
    chk("t5_hold_busy", 32'(busy_seen), 0);
    release_hold();
    arm();
    send_frame(256, 255, -1, -1, -1);
    chk("t5_writes", 32'(wr_n), 256);
    chk("t5_frame_cnt", 32'(frame_cnt), 3);
    release_hold();

    // 3: early eop at sample 100, then auto re-arm
    clr_log();
    arm();
    send_frame(101, 100, -1, -1, -1);
    step(12);
    chk("t3_writes", 32'(wr_n), 100);
    chk("t3_d5", wr_log[5], 312);
    chk("t3_flush_cycles", 32'(flush_n), 8);
    chk("t3_err_pulses", 32'(err_n), 1);
    chk("t3_err_cnt", 32'(err_cnt), 1);
    chk("t3_done_n", 32'(done_n), 0);
    chk("t3_rearmed_busy", 32'(busy), 1);
    clr_log();
    send_frame(256, 255, -1, -1, -1);
    chk("t3_next_writes", 32'(wr_n), 256);
    chk("t3_frame_cnt", 32'(frame_cnt), 4);
    release_hold();

    // 4: fifo_full at sample 50, then a stray sop at sample 30
    clr_log();
    arm();
    send_frame(256, 255, -1, 50, -1);
    chk("t4_full_writes", 32'(wr_n), 50);
    chk("t4_full_flush", 32'(flush_n), 8);
    chk("t4_full_err_cnt", 32'(err_cnt), 2);
    clr_log();
    send_frame(256, 255, 30, -1, -1);
    chk("t4_sop_writes", 32'(wr_n), 30);
    chk("t4_sop_flush", 32'(flush_n), 8);
    chk("t4_sop_err_pulses", 32'(err_n), 1);
    chk("t4_sop_err_cnt", 32'(err_cnt), 3);
    chk("t4_frame_cnt", 32'(frame_cnt), 4);

    // 6: reset in the middle of a capture
    clr_log();
    send_frame(120, -1, -1, -1, -1);
    chk("t6_pre_writes", 32'(wr_n), 120);
    chk("t6_pre_busy", 32'(busy), 1);
    fft_valid = 1'b1;
    fft_data  = 32'(120000);
    data_req  = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("t6_rst_wr_req", 32'(fifo_wr_req), 0);
    chk("t6_rst_wr_data", fifo_wr_data, 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_frame_cnt", 32'(frame_cnt), 0);
    chk("t6_rst_err_cnt", 32'(err_cnt), 0);
    step(3);
    fft_valid = 1'b0;
    rst_n     = 1'b1;
    step(5);
    clr_log();
    send_frame(256, 255, -1, -1, -1);
    chk("t6_noreq_writes", 32'(wr_n), 0);
    chk("t6_noreq_busy", 32'(busy_seen), 0);
    arm();
    send_frame(256, 255, -1, -1, -1);
    chk("t6_writes", 32'(wr_n), 256);
    chk("t6_frame_cnt", 32'(frame_cnt), 1);
    chk("t6_err_cnt", 32'(err_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
